hw_sw_irq_ctrl: RTL and testbench
=================================

Name: hw_sw_irq_ctrl

Overview:
Interrupt scheduler for the host/hardware pointer synchronisation path. It compares the hardware-produced pointer with the host-written pointer (the 64-bit sw_pointer), applies a moderation hold-off, and runs the MSI request handshake with the Virtex-5 PCIe endpoint cfg interface. It sits between the rx/tx DMA engines, which supply hw_pointer, and the endpoint cfg port. It guarantees at most one outstanding interrupt per host acknowledgement.

Parameters:
HOLDOFF_CYCLES, 250, trn_clk cycles that out-of-synch must persist before an MSI is requested (0 = request on the next cycle)
RESEND_CYCLES, 250000, cycles in WAIT_ACK before a lost-interrupt resend (used only with the optional feature)
CNT_W, 20, width of the internal hold-off/resend down-counter; must hold max(HOLDOFF_CYCLES, RESEND_CYCLES)

Ports:
trn_clk  in  1  endpoint transaction clock; the only clock
reset  in  1  synchronous, active-high reset
hw_pointer  in  64  pointer last published by the hardware engine
sw_pointer  in  64  pointer last written by the host
irq_en  in  1  host interrupt enable (register bit), level
cfg_interrupt_rdy_n  in  1  endpoint grant, active low
cfg_interrupt_n  out  1  MSI request, active low
cfg_interrupt_assert_n  out  1  constant 1 (MSI only, no legacy INTx)
cfg_interrupt_di  out  8  constant 8'h00 (MSI vector 0)
irq_count  out  32  number of completed MSI handshakes, wraps
irq_pending  out  1  high while in REQ or WAIT_ACK

Behaviour:
- Reset: state=IDLE, cfg_interrupt_n=1, irq_count=0, irq_pending=0, counter=0, sw_snap=0. Reset wins over every other event in the same cycle. Reset during REQ drops the request immediately; the endpoint sees cfg_interrupt_n=1 on the cycle after reset is sampled.
- oos = (hw_pointer != sw_pointer): full 64-bit compare, registered one cycle. All decisions below use the registered oos, so response latency is +1 cycle from a pointer change.
- One-hot FSM states: IDLE, HOLDOFF, REQ, WAIT_ACK.
- IDLE: if irq_en && oos, load counter=HOLDOFF_CYCLES and go to HOLDOFF. If HOLDOFF_CYCLES==0, go straight to REQ instead.
- HOLDOFF: counter decrements each cycle. If !oos or !irq_en, go to IDLE (no interrupt). When counter==1 and still oos, go to REQ. The first cfg_interrupt_n=0 therefore appears HOLDOFF_CYCLES+1 cycles after oos rises.
- REQ: cfg_interrupt_n=0, held until cfg_interrupt_rdy_n==0 is sampled in the same cycle. The request cannot be withdrawn: irq_en falling or oos clearing in REQ does not abort it. On grant: cfg_interrupt_n=1 on the next cycle, irq_count+=1, sw_snap<=sw_pointer, go to WAIT_ACK.
- WAIT_ACK: go to IDLE when sw_pointer != sw_snap (host consumed or acknowledged), when !oos, or when !irq_en. If the host writes sw_pointer with an unchanged value, the block stays in WAIT_ACK.
- irq_pending = state is REQ or WAIT_ACK, registered.
- irq_count wraps from 32'hFFFFFFFF to 0.
- Simultaneous grant and sw_pointer change: the grant completes first; the change is evaluated in WAIT_ACK on the following cycle.

Optional Feature:
Macro HW_SW_IRQ_RESEND_EN.
- Defined: entering WAIT_ACK loads counter=RESEND_CYCLES. If the counter reaches 0 while still oos, irq_en is high and sw_pointer==sw_snap, the FSM returns to REQ and re-issues the MSI; irq_count increments again on grant.
- Undefined: no resend counter logic. WAIT_ACK waits indefinitely for one of its exit conditions.

Decomposition:
- Shared package include: one-hot state encodings, MSI constants (assert_n=1, vector 8'h00).
- Sub-module hw_sw_irq_timer: loadable down-counter with load, value and zero flag, instantiated once and shared by HOLDOFF and resend.
- Compare, FSM and counters stay in the top module.

Test Plan:
- HOLDOFF_CYCLES=4, irq_en=1, hw_pointer=5, sw_pointer=0, rdy_n tied low -> cfg_interrupt_n low for exactly 1 cycle, 5 cycles after oos is registered; irq_count=1.
- oos for 2 cycles then sw_pointer=hw_pointer during HOLDOFF -> no request; state back to IDLE; irq_count=0.
- REQ with rdy_n held high 10 cycles, irq_en dropped at cycle 3 -> cfg_interrupt_n stays low until rdy_n=0, then releases; irq_count=1.
- After grant, sw_pointer 0->3 with hw_pointer=5 -> IDLE, new HOLDOFF, second MSI; irq_count=2.
- Resend enabled, RESEND_CYCLES=20, sw_pointer frozen -> second MSI about 20 cycles after the first grant. Disabled -> none within 1000 cycles.
- Reset asserted while cfg_interrupt_n=0 -> cfg_interrupt_n=1 next cycle, irq_count=0, irq_pending=0.

Source files
------------

// File: rtl/hw_sw_irq_ctrl_pkg.sv
// Shared types and constants for the hw/sw pointer MSI scheduler.
// Optional resend behaviour is selected with HW_SW_IRQ_RESEND_EN.
package hw_sw_irq_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'b0001,
    ST_HOLDOFF  = 4'b0010,
    ST_REQ      = 4'b0100,
    ST_WAIT_ACK = 4'b1000
  } state_e;

  // MSI only: legacy INTx is never asserted and vector 0 is always used.
  localparam logic       MSI_ASSERT_N = 1'b1;
  localparam logic [7:0] MSI_VECTOR   = 8'h00;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hw_sw_irq_timer.sv
// Loadable down-counter shared by the hold-off and resend intervals.
// Counts down to zero and parks there; load takes priority over counting.
module hw_sw_irq_timer
  import hw_sw_irq_ctrl_pkg::*;
#(
  parameter int CNT_W    = 20,
  parameter int MAX_LOAD = 250000
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] value,
  output logic             zero
);

  localparam logic [CNT_W-1:0] MAX_VAL = CNT_W'(MAX_LOAD);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Loads beyond the configured maximum saturate rather than wrap.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = (load_val > MAX_VAL) ? MAX_VAL : load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign value = cnt_q;
  assign zero  = (cnt_q == '0);

endmodule

// File: rtl/hw_sw_irq_ctrl.sv
// Pointer out-of-synch MSI scheduler with moderation hold-off and one-shot handshake.
// Define HW_SW_IRQ_RESEND_EN to re-issue an MSI the host appears to have lost.
module hw_sw_irq_ctrl
  import hw_sw_irq_ctrl_pkg::*;
#(
  parameter int HOLDOFF_CYCLES = 250,
  parameter int RESEND_CYCLES  = 250000,
  parameter int CNT_W          = 20
) (
  input  logic        trn_clk,
  input  logic        reset,
  input  logic [63:0] hw_pointer,
  input  logic [63:0] sw_pointer,
  input  logic        irq_en,
  input  logic        cfg_interrupt_rdy_n,
  output logic        cfg_interrupt_n,
  output logic        cfg_interrupt_assert_n,
  output logic [7:0]  cfg_interrupt_di,
  output logic [31:0] irq_count,
  output logic        irq_pending
);

  localparam int               MAX_LOAD     = max_int(HOLDOFF_CYCLES, RESEND_CYCLES);
  localparam logic [CNT_W-1:0] HOLDOFF_LOAD = CNT_W'(HOLDOFF_CYCLES);
  localparam logic [CNT_W-1:0] ONE          = CNT_W'(1);
`ifdef HW_SW_IRQ_RESEND_EN
  localparam logic [CNT_W-1:0] RESEND_LOAD  = CNT_W'(RESEND_CYCLES);
`endif

  state_e      state_q, state_d;
  logic        oos_q, oos_d;
  logic        cfg_int_n_q, cfg_int_n_d;
  logic [31:0] irq_count_q, irq_count_d;
  logic        pending_q, pending_d;
  logic [63:0] sw_snap_q, sw_snap_d;

  logic             timer_load;
  logic [CNT_W-1:0] timer_val;
  logic [CNT_W-1:0] timer_value;
  logic             timer_zero;

  hw_sw_irq_timer #(
    .CNT_W    (CNT_W),
    .MAX_LOAD (MAX_LOAD)
  ) u_timer (
    .clk      (trn_clk),
    .srst     (reset),
    .load     (timer_load),
    .load_val (timer_val),
    .value    (timer_value),
    .zero     (timer_zero)
  );

  always_comb begin
    state_d     = state_q;
    oos_d       = (hw_pointer != sw_pointer);
    cfg_int_n_d = cfg_int_n_q;
    irq_count_d = irq_count_q;
    sw_snap_d   = sw_snap_q;
    timer_load  = 1'b0;
    timer_val   = HOLDOFF_LOAD;

    case (state_q)
      ST_IDLE: begin
        if (irq_en && oos_q) begin
          if (HOLDOFF_CYCLES == 0) begin
            state_d     = ST_REQ;
            cfg_int_n_d = 1'b0;
          end else begin
            state_d    = ST_HOLDOFF;
            timer_load = 1'b1;
          end
        end
      end
      ST_HOLDOFF: begin
        if (!oos_q || !irq_en) begin
          state_d = ST_IDLE;
        end else if (timer_value == ONE || timer_zero) begin
          state_d     = ST_REQ;
          cfg_int_n_d = 1'b0;
        end
      end
      // Once raised, the request is held until the endpoint grants it.
      ST_REQ: begin
        if (!cfg_interrupt_rdy_n) begin
          state_d     = ST_WAIT_ACK;
          cfg_int_n_d = 1'b1;
          irq_count_d = irq_count_q + 32'd1;
          sw_snap_d   = sw_pointer;
`ifdef HW_SW_IRQ_RESEND_EN
          timer_load  = 1'b1;
          timer_val   = RESEND_LOAD;
`endif
        end
      end
      ST_WAIT_ACK: begin
        if (sw_pointer != sw_snap_q || !oos_q || !irq_en) begin
          state_d = ST_IDLE;
`ifdef HW_SW_IRQ_RESEND_EN
        end else if (timer_zero) begin
          state_d     = ST_REQ;
          cfg_int_n_d = 1'b0;
`endif
        end
      end
      default: begin
        state_d     = ST_IDLE;
        cfg_int_n_d = 1'b1;
      end
    endcase

    pending_d = (state_d == ST_REQ) || (state_d == ST_WAIT_ACK);
  end

  always_ff @(posedge trn_clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      oos_q       <= 1'b0;
      cfg_int_n_q <= 1'b1;
      irq_count_q <= '0;
      pending_q   <= 1'b0;
      sw_snap_q   <= '0;
    end else begin
      state_q     <= state_d;
      oos_q       <= oos_d;
      cfg_int_n_q <= cfg_int_n_d;
      irq_count_q <= irq_count_d;
      pending_q   <= pending_d;
      sw_snap_q   <= sw_snap_d;
    end
  end

  assign cfg_interrupt_n        = cfg_int_n_q;
  assign cfg_interrupt_assert_n = MSI_ASSERT_N;
  assign cfg_interrupt_di       = MSI_VECTOR;
  assign irq_count              = irq_count_q;
  assign irq_pending            = pending_q;

endmodule

// File: tb/tb_hw_sw_irq_ctrl.sv
// Directed bench for hw_sw_irq_ctrl; grants are scored against a queue of expected irq_count values.
// Built with or without HW_SW_IRQ_RESEND_EN; the resend step adapts to the build.
module tb_hw_sw_irq_ctrl;

  logic        trn_clk;
  logic        reset;
  logic [63:0] hw_pointer;
  logic [63:0] sw_pointer;
  logic        irq_en;
  logic        cfg_interrupt_rdy_n;
  logic        cfg_interrupt_n;
  logic        cfg_interrupt_assert_n;
  logic [7:0]  cfg_interrupt_di;
  logic [31:0] irq_count;
  logic        irq_pending;

  int compared   = 0;
  int mismatched = 0;
  logic [31:0] exp_q[$];

  hw_sw_irq_ctrl #(
    .HOLDOFF_CYCLES (4),
    .RESEND_CYCLES  (20),
    .CNT_W          (20)
  ) dut (
    .trn_clk                (trn_clk),
    .reset                  (reset),
    .hw_pointer             (hw_pointer),
    .sw_pointer             (sw_pointer),
    .irq_en                 (irq_en),
    .cfg_interrupt_rdy_n    (cfg_interrupt_rdy_n),
    .cfg_interrupt_n        (cfg_interrupt_n),
    .cfg_interrupt_assert_n (cfg_interrupt_assert_n),
    .cfg_interrupt_di       (cfg_interrupt_di),
    .irq_count              (irq_count),
    .irq_pending            (irq_pending)
  );

  initial trn_clk = 1'b0;
  always #5 trn_clk = ~trn_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge trn_clk);
    #1;
  endtask

  // Ticks until cfg_interrupt_n is seen low; n = ticks taken, or -1 if the bound expires.
  task automatic wait_req(input int max_cyc, output int n);
    n = -1;
    for (int i = 1; i <= max_cyc; i++) begin
      tick();
      if (cfg_interrupt_n === 1'b0) begin
        n = i;
        break;
      end
    end
  endtask

  // Scoreboard: each completed handshake pops the irq_count it should produce.
  always @(negedge trn_clk) begin
    if (reset === 1'b0 && cfg_interrupt_n === 1'b0 && cfg_interrupt_rdy_n === 1'b0) begin
      logic [31:0] exp_cnt;
      @(posedge trn_clk);
      #1;
      exp_cnt = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
      check("grant_irq_count", irq_count, exp_cnt);
      $display("grant: irq_count=%0d expected=%0d", irq_count, exp_cnt);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    bit  req_seen;

    reset = 1'b1;
    hw_pointer = 64'd0;
    sw_pointer = 64'd0;
    irq_en = 1'b0;
    cfg_interrupt_rdy_n = 1'b0;
    tick();
    tick();
    check("reset_cfg_n", cfg_interrupt_n, 1);
    check("reset_count", irq_count, 0);
    check("reset_pending", irq_pending, 0);
    check("assert_n_const", cfg_interrupt_assert_n, 1);
    check("vector_const", cfg_interrupt_di, 0);
    reset = 1'b0;
    irq_en = 1'b1;
    tick();
    tick();

    // Basic: hw=5, sw=0, grant tied low.
    exp_q.push_back(32'd1);
    hw_pointer = 64'd5;
    wait_req(50, n);
    check("basic_req_latency", n, 6);
    check("basic_pending_req", irq_pending, 1);
    tick();
    check("basic_one_cycle_low", cfg_interrupt_n, 1);
    check("basic_count", irq_count, 1);
    check("basic_pending_wait", irq_pending, 1);
    $display("basic: req after %0d ticks, irq_count=%0d", n, irq_count);

    // Host advances sw_pointer but is still behind: second MSI after a fresh hold-off.
    exp_q.push_back(32'd2);
    sw_pointer = 64'd3;
    tick();
    check("ack_to_idle_pending", irq_pending, 0);
    wait_req(50, n);
    check("second_req_latency", n, 5);
    tick();
    check("second_count", irq_count, 2);
    $display("second: req after %0d more ticks, irq_count=%0d", n, irq_count);

    sw_pointer = 64'd5;
    tick(); tick(); tick();
    check("in_synch_pending", irq_pending, 0);

    // Out-of-synch for two cycles, then cleared during HOLDOFF: no request.
    hw_pointer = 64'd9;
    tick(); tick();
    sw_pointer = 64'd9;
    req_seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (cfg_interrupt_n !== 1'b1) req_seen = 1'b1;
    end
    check("abort_no_req", req_seen, 0);
    check("abort_pending", irq_pending, 0);
    check("abort_count", irq_count, 2);
    $display("abort: request seen=%0d irq_count=%0d", req_seen, irq_count);

    // REQ held against a busy endpoint; dropping irq_en does not withdraw it.
    cfg_interrupt_rdy_n = 1'b1;
    hw_pointer = 64'd12;
    wait_req(50, n);
    check("busy_req_latency", n, 6);
    req_seen = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      if (i == 3) irq_en = 1'b0;
      tick();
      if (cfg_interrupt_n !== 1'b0) req_seen = 1'b0;
    end
    check("busy_req_held", req_seen, 1);
    check("busy_pending", irq_pending, 1);
    exp_q.push_back(32'd3);
    cfg_interrupt_rdy_n = 1'b0;
    tick();
    check("busy_release", cfg_interrupt_n, 1);
    check("busy_count", irq_count, 3);
    tick();
    check("irq_dis_to_idle", irq_pending, 0);
    $display("busy: held 10 cycles, irq_count=%0d", irq_count);

    // Re-enable with sw_pointer frozen, then look for a lost-interrupt resend.
    exp_q.push_back(32'd4);
    irq_en = 1'b1;
    wait_req(50, n);
    check("reenable_req_latency", n, 5);
    tick();
    check("reenable_count", irq_count, 4);
`ifdef HW_SW_IRQ_RESEND_EN
    exp_q.push_back(32'd5);
    wait_req(1000, n);
    check("resend_seen", (n >= 18 && n <= 24), 1);
    tick();
    check("resend_count", irq_count, 5);
    $display("resend: second MSI after %0d ticks, irq_count=%0d", n, irq_count);
`else
    wait_req(1000, n);
    check("no_resend", n, -1);
    check("no_resend_count", irq_count, 4);
    $display("no resend: wait result=%0d irq_count=%0d", n, irq_count);
`endif

    // Reset while a request is outstanding.
    cfg_interrupt_rdy_n = 1'b1;
    sw_pointer = 64'd12;
    tick(); tick(); tick();
    hw_pointer = 64'd20;
    wait_req(50, n);
    check("pre_reset_req", cfg_interrupt_n, 0);
    reset = 1'b1;
    tick();
    check("reset_drop_cfg_n", cfg_interrupt_n, 1);
    check("reset_drop_count", irq_count, 0);
    check("reset_drop_pending", irq_pending, 0);
    $display("reset in REQ: cfg_n=%0d irq_count=%0d pending=%0d", cfg_interrupt_n, irq_count, irq_pending);
    reset = 1'b0;
    tick();

    check("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
